// File: rtl/adc_aperture_timer.sv
// ADC aperture timer: trigger/valid handshake, integrator-reset phase, then a programmable aperture phase.
// Optional result-ready interrupt register enabled by defining ADC_INTERRUPT_EN.
module adc_aperture_timer #(
    parameter int CW = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adc_measure_trig,
    input  logic [CW-1:0] p_clk_count_reset,
    input  logic [CW-1:0] p_clk_count_aper,
    output logic          adc_measure_valid,
    output logic          int_reset,
    output logic          int_run,
    output logic [23:0]   measure_count,
    output logic [CW-1:0] clk_count_aper_last,
    output logic          adc_interrupt,
    output logic [1:0]    monitor
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_APER,
        S_WAIT_TRIG_LOW
    } state_t;

    state_t        state, state_nx;
    logic [31:0]   cnt, cnt_nx;
    logic [CW-1:0] aper_shadow;
    logic          start;
    logic          meas_done;
    logic          phase_done;

    // A zero-length phase still occupies one clock.
    function automatic logic [CW-1:0] clamp_len(input logic [CW-1:0] len);
        return (len == '0) ? CW'(1) : len;
    endfunction

    // The counter holds the number of cycles remaining after the current one.
    function automatic logic [31:0] cnt_load(input logic [CW-1:0] len);
        logic [31:0] v;
        v = 32'(clamp_len(len));
        return v - 32'd1;
    endfunction

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        start      = 1'b0;
        meas_done  = 1'b0;
        phase_done = (cnt == 32'd0);
        case (state)
            S_IDLE: begin
                if (adc_measure_trig) begin
                    state_nx = S_RESET;
                    cnt_nx   = cnt_load(p_clk_count_reset);
                    start    = 1'b1;
                end
            end
            S_RESET: begin
                if (phase_done) begin
                    state_nx = S_APER;
                    cnt_nx   = cnt_load(aper_shadow);
                end else begin
                    cnt_nx = cnt - 32'd1;
                end
            end
            S_APER: begin
                if (phase_done) begin
                    meas_done = 1'b1;
                    state_nx  = adc_measure_trig ? S_WAIT_TRIG_LOW : S_IDLE;
                end else begin
                    cnt_nx = cnt - 32'd1;
                end
            end
            S_WAIT_TRIG_LOW: begin
                if (!adc_measure_trig) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Switch controls are registered from the next state so they never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= S_IDLE;
            adc_measure_valid   <= 1'b1;
            int_reset           <= 1'b0;
            int_run             <= 1'b0;
            measure_count       <= 24'd0;
            clk_count_aper_last <= '0;
        end else begin
            state             <= state_nx;
            adc_measure_valid <= (state_nx == S_IDLE);
            int_reset         <= (state_nx == S_RESET);
            int_run           <= (state_nx == S_APER);
            if (meas_done) begin
                measure_count       <= measure_count + 24'd1;
                clk_count_aper_last <= clamp_len(aper_shadow);
            end
        end
    end

    // Datapath registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        cnt <= cnt_nx;
        if (start) begin
            aper_shadow <= p_clk_count_aper;
        end
    end

`ifdef ADC_INTERRUPT_EN
    logic irq;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else if (meas_done) begin
            irq <= 1'b1;
        end else if (start) begin
            irq <= 1'b0;
        end
    end

    assign adc_interrupt = irq;
`else
    assign adc_interrupt = 1'b0;
`endif

    assign monitor = {adc_measure_valid, int_run};

endmodule
